// File: rtl/seven_seg_pkg.sv
// Shared segment encodings for the scanned seven-segment controller.
// Patterns are active-high {g,f,e,d,c,b,a}; pin polarity is applied at the output registers.
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Display-side bundle: datapath request signals in, scanned pin drives out.
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4,
    parameter int PWM_BITS   = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    lzb_en;
    logic [PWM_BITS-1:0]     brightness;
    logic                    load;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_start;

    modport master (
        output digits, dp_in, blank, lzb_en, brightness, load,
        input  an, seg, dp, frame_start
    );

    modport slave (
        input  digits, dp_in, blank, lzb_en, brightness, load,
        output an, seg, dp, frame_start
    );
endinterface

// File: rtl/hex_to_seven_seg.sv
// Combinational nibble to active-high segment pattern lookup.
module hex_to_seven_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);
    assign pattern = HEX_SEG[nibble];
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed N-digit seven-segment scanner with frame-synchronous updates,
// leading-zero blanking and PWM brightness; all pin drives are registered.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIVIDE_BY  = 17,
    parameter int PWM_BITS   = 4,
    parameter int ACTIVE_LOW = 1
) (
    input logic clock,
    input logic reset_n,
    seven_seg_scan_ctrl_if.slave disp
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [DIVIDE_BY-1:0]    presc;
    logic [IDX_W-1:0]        idx;
    logic                    tick;
    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] stg_digits, act_digits;
    logic [NUM_DIGITS-1:0]   stg_dp, act_dp;
    logic [NUM_DIGITS-1:0]   stg_blank, act_blank;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    lz_run;
    logic [PWM_BITS-1:0]     pwm_phase;
    logic                    pwm_on;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_on;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              pattern;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic                    fs_q;

    assign tick = &presc;
    assign wrap = tick && (idx == LAST_IDX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= presc + DIVIDE_BY'(1);
            if (tick) idx <= wrap ? '0 : idx + IDX_W'(1);
        end
    end

    // A load on the wrap edge goes straight to the active set so it is not lost for a frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stg_digits <= '0;
            stg_dp     <= '0;
            stg_blank  <= '0;
            act_digits <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
        end else begin
            if (disp.load) begin
                stg_digits <= disp.digits;
                stg_dp     <= disp.dp_in;
                stg_blank  <= disp.blank;
            end
            if (wrap) begin
                act_digits <= disp.load ? disp.digits : stg_digits;
                act_dp     <= disp.load ? disp.dp_in  : stg_dp;
                act_blank  <= disp.load ? disp.blank  : stg_blank;
            end
        end
    end

    // Zero run from the top digit down; a decimal point ends the run.
    always_comb begin
        lz_mask = '0;
        lz_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz_run     = lz_run && (act_digits[4*i +: 4] == 4'h0) && !act_dp[i];
            lz_mask[i] = lz_run;
        end
    end

    assign pwm_phase = presc[DIVIDE_BY-1 -: PWM_BITS];
    assign pwm_on    = (disp.brightness == '1) || (pwm_phase < disp.brightness);

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_on  = 1'b0;
        an_next = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib    = act_digits[4*i +: 4];
                cur_dp     = act_dp[i];
                cur_on     = !act_blank[i] && !(disp.lzb_en && lz_mask[i]) && pwm_on;
                an_next[i] = cur_on;
            end
        end
    end

    hex_to_seven_seg u_hex (
        .nibble  (cur_nib),
        .pattern (pattern)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            an_q  <= {NUM_DIGITS{POL}};
            seg_q <= SEG_OFF ^ {7{POL}};
            dp_q  <= POL;
            fs_q  <= 1'b0;
        end else begin
            an_q  <= an_next ^ {NUM_DIGITS{POL}};
            seg_q <= (cur_on ? pattern : SEG_OFF) ^ {7{POL}};
            dp_q  <= (cur_on && cur_dp) ^ POL;
            fs_q  <= (idx == '0) && (presc == '0);
        end
    end

    assign disp.an          = an_q;
    assign disp.seg         = seg_q;
    assign disp.dp          = dp_q;
    assign disp.frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for the scanned display: 4 digits, 4-clock slots, 2-bit PWM, active-low pins.
module tb_seven_seg_scan_ctrl;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(4), .PWM_BITS(2)) disp ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS (4),
        .DIVIDE_BY  (2),
        .PWM_BITS   (2),
        .ACTIVE_LOW (1)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .disp    (disp)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!disp.frame_start && n < 64);
        if (!disp.frame_start) check_val("frame_timeout", 32'd0, 32'd1);
    endtask

    // Called on the negedge where frame_start is seen; walks all 16 slot/phase steps.
    task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] lit,
                               input logic [3:0] dps, input int bright, input bit do_load,
                               input logic [15:0] ld_digits, input logic [3:0] ld_dp,
                               input logic [3:0] ld_blank, input int load_at);
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        logic       on;
        for (int n = 0; n < 16; n++) begin
            int s, p;
            s = n / 4;
            p = n % 4;
            if (n > 0) @(negedge clock);
            on      = lit[s] && (bright == 3 || p < bright);
            exp_an  = on ? ~(4'b0001 << s) : 4'hF;
            exp_seg = on ? segs[7*s +: 7] : 7'h7F;
            exp_dp  = on ? ~dps[s] : 1'b1;
            check_val($sformatf("%s_n%0d_an", tag, n), {28'd0, disp.an}, {28'd0, exp_an});
            check_val($sformatf("%s_n%0d_seg", tag, n), {25'd0, disp.seg}, {25'd0, exp_seg});
            check_val($sformatf("%s_n%0d_dp", tag, n), {31'd0, disp.dp}, {31'd0, exp_dp});
            check_val($sformatf("%s_n%0d_fs", tag, n), {31'd0, disp.frame_start},
                      {31'd0, (n == 0)});
            if (do_load && n == load_at) begin
                disp.digits = ld_digits;
                disp.dp_in  = ld_dp;
                disp.blank  = ld_blank;
                disp.load   = 1'b1;
            end else begin
                disp.load = 1'b0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        disp.digits     = 16'h0000;
        disp.dp_in      = 4'h0;
        disp.blank      = 4'h0;
        disp.lzb_en     = 1'b0;
        disp.brightness = 2'b11;
        disp.load       = 1'b0;

        repeat (3) @(negedge clock);
        check_val("rst_an", {28'd0, disp.an}, 32'hF);
        check_val("rst_seg", {25'd0, disp.seg}, 32'h7F);
        check_val("rst_dp", {31'd0, disp.dp}, 32'h1);
        check_val("rst_fs", {31'd0, disp.frame_start}, 32'h0);
        reset_n = 1'b1;

        wait_frame(nw);
        check_val("first_frame_lat", nw, 32'd1);
        check_frame("zero", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'h0, 3,
                    1'b1, 16'h1234, 4'h0, 4'h0, 0);
        wait_frame(nw);
        check_frame("d1234", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'h0, 3,
                    1'b1, 16'hABCD, 4'h0, 4'h0, 0);
        wait_frame(nw);
        check_frame("dABCD", {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF, 4'h0, 3,
                    1'b1, 16'h5678, 4'h0, 4'h0, 14);
        disp.lzb_en = 1'b1;
        wait_frame(nw);
        check_frame("d5678", {7'h12, 7'h02, 7'h78, 7'h00}, 4'hF, 4'h0, 3,
                    1'b1, 16'h0050, 4'h0, 4'h0, 0);
        wait_frame(nw);
        check_frame("lzb0050", {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b0011, 4'h0, 3,
                    1'b1, 16'h0000, 4'h0, 4'h0, 0);
        wait_frame(nw);
        check_frame("lzb0000", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001, 4'h0, 3,
                    1'b1, 16'h0000, 4'b0100, 4'h0, 0);
        wait_frame(nw);
        check_frame("lzb_dp", {7'h7F, 7'h40, 7'h40, 7'h40}, 4'b0111, 4'b0100, 3,
                    1'b1, 16'h1234, 4'b0001, 4'b0010, 0);
        wait_frame(nw);
        check_frame("blank_dp", {7'h79, 7'h24, 7'h7F, 7'h19}, 4'b1101, 4'b0001, 3,
                    1'b0, 16'h0000, 4'h0, 4'h0, 0);
        disp.brightness = 2'b01;
        wait_frame(nw);
        check_frame("pwm1", {7'h79, 7'h24, 7'h7F, 7'h19}, 4'b1101, 4'b0001, 1,
                    1'b0, 16'h0000, 4'h0, 4'h0, 0);
        disp.brightness = 2'b00;
        wait_frame(nw);
        check_frame("pwm0", {7'h79, 7'h24, 7'h7F, 7'h19}, 4'b1101, 4'b0001, 0,
                    1'b0, 16'h0000, 4'h0, 4'h0, 0);
        disp.brightness = 2'b11;
        disp.lzb_en     = 1'b0;

        wait_frame(nw);
        repeat (8) @(negedge clock);
        check_val("pre_rst_an", {28'd0, disp.an}, 32'hB);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check_val("mid_rst_an", {28'd0, disp.an}, 32'hF);
        check_val("mid_rst_seg", {25'd0, disp.seg}, 32'h7F);
        check_val("mid_rst_dp", {31'd0, disp.dp}, 32'h1);
        check_val("mid_rst_fs", {31'd0, disp.frame_start}, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        wait_frame(nw);
        check_val("rst_restart_lat", nw, 32'd1);
        check_frame("after_rst", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'h0, 3,
                    1'b0, 16'h0000, 4'h0, 4'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
